// File: rtl/spi_response_transmitter.sv
// SD-card SPI-mode response serialiser: takes an R1 or R3/R7 response over a
// valid/ready handshake, sends NCR filler bytes, then shifts the response out on SPI_CLK falls.
module spi_response_transmitter #(
  parameter int NCR_BYTES = 1,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_SPI_CLK,
  input  logic        io_SPI_CS,
  output logic        io_SPI_DO,
  input  logic        io_RespValid,
  output logic        io_RespReady,
  input  logic        io_RespLong,
  input  logic [39:0] io_RespData,
  output logic        io_Busy,
  output logic        io_Done,
  output logic [1:0]  io____state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NCR  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] FILL_INIT = 4'(NCR_BYTES);

  state_t      state;
  state_t      state_next;
  logic        sclk_meta;
  logic        sclk_sync;
  logic        sclk_prev;
  logic [2:0]  bit_cnt;
  logic [2:0]  bit_cnt_next;
  logic [3:0]  fill_cnt;
  logic [3:0]  fill_cnt_next;
  logic [2:0]  byte_cnt;
  logic [2:0]  byte_cnt_next;
  logic [39:0] shift_reg;
  logic [39:0] shift_reg_next;
  logic        do_reg;
  logic        do_next;
  logic        fall;
  logic        accept;

  // Selects bit idx of a byte in transmit order, so idx 0 is always the first bit out.
  function automatic logic pick_bit(input logic [7:0] b, input logic [2:0] idx);
    if (LSB_FIRST) begin
      return b[idx];
    end
    return b[3'd7 - idx];
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sclk_meta <= 1'b0;
      sclk_sync <= 1'b0;
      sclk_prev <= 1'b0;
    end else begin
      sclk_meta <= io_SPI_CLK;
      sclk_sync <= sclk_meta;
      sclk_prev <= sclk_sync;
    end
  end

  // Rising edges are of no interest: the host samples on them while we hold DO steady.
  assign fall   = sclk_prev & ~sclk_sync & ~io_SPI_CS;
  assign accept = io_RespValid & io_RespReady;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      fill_cnt  <= 4'd0;
      byte_cnt  <= 3'd0;
      shift_reg <= 40'd0;
      do_reg    <= 1'b1;
    end else begin
      state     <= state_next;
      bit_cnt   <= bit_cnt_next;
      fill_cnt  <= fill_cnt_next;
      byte_cnt  <= byte_cnt_next;
      shift_reg <= shift_reg_next;
      do_reg    <= do_next;
    end
  end

  always_comb begin
    state_next     = state;
    bit_cnt_next   = bit_cnt;
    fill_cnt_next  = fill_cnt;
    byte_cnt_next  = byte_cnt;
    shift_reg_next = shift_reg;
    do_next        = do_reg;

    case (state)
      IDLE: begin
        do_next = 1'b1;
        if (accept) begin
          state_next     = NCR;
          bit_cnt_next   = 3'd0;
          fill_cnt_next  = FILL_INIT;
          byte_cnt_next  = io_RespLong ? 3'd5 : 3'd1;
          shift_reg_next = io_RespData;
        end
      end

      NCR: begin
        if (io_SPI_CS) begin
          state_next     = IDLE;
          do_next        = 1'b1;
          bit_cnt_next   = 3'd0;
          fill_cnt_next  = 4'd0;
          byte_cnt_next  = 3'd0;
          shift_reg_next = 40'd0;
        end else if (fall) begin
          if (bit_cnt == 3'd7) begin
            bit_cnt_next  = 3'd0;
            fill_cnt_next = fill_cnt - 4'd1;
            // The last filler fall already drives the first response bit.
            if (fill_cnt <= 4'd1) begin
              fill_cnt_next = 4'd0;
              state_next    = DATA;
              do_next       = pick_bit(shift_reg[39:32], 3'd0);
            end
          end else begin
            bit_cnt_next = bit_cnt + 3'd1;
          end
        end
      end

      DATA: begin
        if (io_SPI_CS) begin
          state_next     = IDLE;
          do_next        = 1'b1;
          bit_cnt_next   = 3'd0;
          byte_cnt_next  = 3'd0;
          shift_reg_next = 40'd0;
        end else if (fall) begin
          if (bit_cnt == 3'd7) begin
            bit_cnt_next = 3'd0;
            if (byte_cnt <= 3'd1) begin
              byte_cnt_next = 3'd0;
              state_next    = DONE;
              do_next       = 1'b1;
            end else begin
              byte_cnt_next  = byte_cnt - 3'd1;
              shift_reg_next = {shift_reg[31:0], 8'h00};
              do_next        = pick_bit(shift_reg[31:24], 3'd0);
            end
          end else begin
            bit_cnt_next = bit_cnt + 3'd1;
            do_next      = pick_bit(shift_reg[39:32], bit_cnt + 3'd1);
          end
        end
      end

      DONE: begin
        state_next     = IDLE;
        do_next        = 1'b1;
        shift_reg_next = 40'd0;
      end

      default: begin
        state_next = IDLE;
        do_next    = 1'b1;
      end
    endcase
  end

  assign io_SPI_DO    = do_reg;
  assign io_RespReady = (state == IDLE);
  assign io_Busy      = (state == NCR) | (state == DATA);
  assign io_Done      = (state == DONE);
  assign io____state  = state;

endmodule

// File: tb/tb_spi_response_transmitter.sv
// Directed bench for spi_response_transmitter: acts as the SPI host (mode 0),
// samples DO on each rising edge and compares against hand-computed bytes.
module tb_spi_response_transmitter;

  localparam int NCR_BYTES = 1;

  logic        clock = 1'b0;
  logic        reset;
  logic        spi_clk;
  logic        spi_cs;
  logic        spi_do;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_long;
  logic [39:0] resp_data;
  logic        busy;
  logic        done;
  logic [1:0]  state_dbg;

  int test_count = 0;
  int fail_count = 0;
  int done_count = 0;

  spi_response_transmitter #(
    .NCR_BYTES(NCR_BYTES),
    .LSB_FIRST(1'b1)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .io_SPI_CLK   (spi_clk),
    .io_SPI_CS    (spi_cs),
    .io_SPI_DO    (spi_do),
    .io_RespValid (resp_valid),
    .io_RespReady (resp_ready),
    .io_RespLong  (resp_long),
    .io_RespData  (resp_data),
    .io_Busy      (busy),
    .io_Done      (done),
    .io____state  (state_dbg)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (done) done_count++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    test_count++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One SPI clock period: rise (host samples DO), then fall, 8 system clocks per phase.
  task automatic spiBit(output logic b, output logic bsy);
    spi_clk = 1'b1;
    b = spi_do;
    bsy = busy;
    repeat (8) @(negedge clock);
    spi_clk = 1'b0;
    repeat (8) @(negedge clock);
  endtask

  task automatic recvBytes(input int n, output logic [39:0] val, output logic busy_all);
    logic [7:0] cur;
    logic b;
    logic bs;
    val = '0;
    busy_all = 1'b1;
    for (int k = 0; k < n; k++) begin
      cur = '0;
      for (int i = 0; i < 8; i++) begin
        spiBit(b, bs);
        busy_all = busy_all & bs;
        cur[i] = b;
      end
      val = {val[31:0], cur};
    end
  endtask

  task automatic applyStimulus(input logic lng, input logic [39:0] data, input bit hold);
    @(negedge clock);
    resp_long  = lng;
    resp_data  = data;
    resp_valid = 1'b1;
    @(negedge clock);
    if (!hold) resp_valid = 1'b0;
  endtask

  task automatic runTransfer(input string tag, input logic lng, input logic [39:0] exp);
    int d0;
    logic [39:0] fill;
    logic [39:0] resp;
    logic ba;
    logic bb;
    d0 = done_count;
    recvBytes(NCR_BYTES, fill, ba);
    checkOutput({tag, "_ncr"}, 64'(fill), 64'h00000000FF);
    recvBytes(lng ? 5 : 1, resp, bb);
    checkOutput({tag, "_data"}, 64'(resp), 64'(exp));
    checkOutput({tag, "_busy"}, 64'(ba & bb), 64'd1);
    checkOutput({tag, "_done"}, 64'(done_count - d0), 64'd1);
    checkOutput({tag, "_do_idle"}, 64'(spi_do), 64'd1);
  endtask

  initial begin
    logic [39:0] v;
    logic ba;
    logic b;
    logic bs;
    int d0;

    reset      = 1'b0;
    spi_clk    = 1'b0;
    spi_cs     = 1'b0;
    resp_valid = 1'b0;
    resp_long  = 1'b0;
    resp_data  = '0;
    repeat (3) @(negedge clock);
    checkOutput("rst_do", 64'(spi_do), 64'd1);
    checkOutput("rst_ready", 64'(resp_ready), 64'd1);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_state", 64'(state_dbg), 64'd0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    applyStimulus(1'b0, {8'h01, 32'h0}, 1'b0);
    checkOutput("r1_acc_busy", 64'(busy), 64'd1);
    checkOutput("r1_acc_state", 64'(state_dbg), 64'd1);
    checkOutput("r1_acc_ready", 64'(resp_ready), 64'd0);
    runTransfer("r1_01", 1'b0, 40'h01);
    checkOutput("r1_end_state", 64'(state_dbg), 64'd0);
    checkOutput("r1_end_ready", 64'(resp_ready), 64'd1);

    applyStimulus(1'b1, 40'h01_000001AA, 1'b0);
    runTransfer("r7", 1'b1, 40'h01_000001AA);

    // Abort with CS after three data bits of R1 0x00.
    applyStimulus(1'b0, 40'h00_00000000, 1'b0);
    d0 = done_count;
    recvBytes(NCR_BYTES, v, ba);
    checkOutput("abort_ncr", 64'(v), 64'hFF);
    for (int i = 0; i < 3; i++) spiBit(b, bs);
    checkOutput("abort_do_pre", 64'(spi_do), 64'd0);
    spi_cs = 1'b1;
    @(negedge clock);
    checkOutput("abort_do", 64'(spi_do), 64'd1);
    checkOutput("abort_state", 64'(state_dbg), 64'd0);
    checkOutput("abort_ready", 64'(resp_ready), 64'd1);
    spiBit(b, bs);
    spi_cs = 1'b0;
    repeat (4) @(negedge clock);
    checkOutput("abort_no_done", 64'(done_count - d0), 64'd0);
    applyStimulus(1'b0, {8'hA5, 32'h0}, 1'b0);
    runTransfer("after_abort", 1'b0, 40'hA5);

    // Asynchronous reset in the middle of the data byte (DO is 0 at that point).
    applyStimulus(1'b0, {8'h3C, 32'h0}, 1'b0);
    recvBytes(NCR_BYTES, v, ba);
    for (int i = 0; i < 6; i++) spiBit(b, bs);
    checkOutput("mid_rst_do_pre", 64'(spi_do), 64'd0);
    #3 reset = 1'b0;
    #1;
    checkOutput("mid_rst_do", 64'(spi_do), 64'd1);
    checkOutput("mid_rst_busy", 64'(busy), 64'd0);
    checkOutput("mid_rst_ready", 64'(resp_ready), 64'd1);
    checkOutput("mid_rst_state", 64'(state_dbg), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    d0 = done_count;
    for (int i = 0; i < 4; i++) begin
      spiBit(b, bs);
      checkOutput("post_rst_do", 64'(b), 64'd1);
    end
    checkOutput("post_rst_state", 64'(state_dbg), 64'd0);
    checkOutput("post_rst_done", 64'(done_count - d0), 64'd0);

    // Valid held high with a new payload while the first is in flight.
    applyStimulus(1'b0, {8'h05, 32'h0}, 1'b1);
    resp_data = {8'h01, 32'h0};
    runTransfer("b2b_first", 1'b0, 40'h05);
    checkOutput("b2b_second_acc", 64'(state_dbg), 64'd1);
    resp_valid = 1'b0;
    runTransfer("b2b_second", 1'b0, 40'h01);
    checkOutput("b2b_end_state", 64'(state_dbg), 64'd0);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
